// File: rtl/forward_hazard_ctl.sv
// EXE-stage forwarding and load-use/MEM-wait hazard control beside ID.
// Optional statistics counters are compiled in when FWD_STATS_EN is defined.
module forward_hazard_ctl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ID_Valid_IN,
    input  logic [REG_W-1:0] ID_rs_IN,
    input  logic [REG_W-1:0] ID_rt_IN,
    input  logic             ID_UsesRs_IN,
    input  logic             ID_UsesRt_IN,
    input  logic [REG_W-1:0] ID_WriteRegister_IN,
    input  logic             ID_RegWrite_IN,
    input  logic             ID_MemRead_IN,
    input  logic             MEM_Ready_IN,
    output logic [1:0]       Fwd2ALU_opA_ctl,
    output logic [1:0]       Fwd2ALU_opB_ctl,
    output logic             STALL_ID_OUT,
    output logic             BUBBLE_EXE_OUT,
    output logic             FREEZE_OUT,
    output logic [CNT_W-1:0] Fwd_Count_OUT,
    output logic [CNT_W-1:0] Stall_Count_OUT
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    localparam logic [1:0] CTL_RF  = 2'b00;
    localparam logic [1:0] CTL_EXE = 2'b01;
    localparam logic [1:0] CTL_MEM = 2'b10;

    state_t r_state;
    state_t r_savedState;
    state_t w_nextState;
    state_t w_effState;

    logic [REG_W-1:0] r_exDst;
    logic             r_exRw;
    logic             r_exMr;
    logic [REG_W-1:0] r_mmDst;
    logic             r_mmRw;

    logic [1:0] r_ctlA;
    logic [1:0] r_ctlB;

    logic       w_useA;
    logic       w_useB;
    logic       w_exWriter;
    logic       w_mmWriter;
    logic       w_matchExA;
    logic       w_matchExB;
    logic       w_matchMmA;
    logic       w_matchMmB;
    logic       w_hazard;
    logic       w_freeze;
    logic       w_advance;
    logic       w_bubble;
    logic [1:0] w_nextA;
    logic [1:0] w_nextB;

    // A waiting pipe resumes exactly where it left off, including a pending load stall.
    assign w_effState = (r_state == MEM_WAIT) ? r_savedState : r_state;

    assign w_useA     = ID_Valid_IN && ID_UsesRs_IN && (ID_rs_IN != '0);
    assign w_useB     = ID_Valid_IN && ID_UsesRt_IN && (ID_rt_IN != '0);
    assign w_exWriter = r_exRw && (r_exDst != '0);
    assign w_mmWriter = r_mmRw && (r_mmDst != '0);
    assign w_matchExA = w_useA && w_exWriter && (ID_rs_IN == r_exDst);
    assign w_matchExB = w_useB && w_exWriter && (ID_rt_IN == r_exDst);
    assign w_matchMmA = w_useA && w_mmWriter && (ID_rs_IN == r_mmDst);
    assign w_matchMmB = w_useB && w_mmWriter && (ID_rt_IN == r_mmDst);

    assign w_hazard  = (w_effState == RUN) && r_exMr && (w_matchExA || w_matchExB);
    assign w_freeze  = !MEM_Ready_IN;
    assign w_advance = !w_freeze;
    assign w_bubble  = w_advance && w_hazard;

    // A load result is never available from EXE/MEM, so a load match falls through to MEM/WB.
    always_comb begin
        w_nextA = CTL_RF;
        w_nextB = CTL_RF;
        if (w_matchExA && !r_exMr) begin
            w_nextA = CTL_EXE;
        end else if (w_matchMmA) begin
            w_nextA = CTL_MEM;
        end
        if (w_matchExB && !r_exMr) begin
            w_nextB = CTL_EXE;
        end else if (w_matchMmB) begin
            w_nextB = CTL_MEM;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= RUN;
            r_savedState <= RUN;
        end else begin
            r_state <= w_nextState;
            if (w_freeze && (r_state != MEM_WAIT)) begin
                r_savedState <= r_state;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (w_freeze) begin
            w_nextState = MEM_WAIT;
        end else if (w_effState == RUN) begin
            w_nextState = w_hazard ? LOAD_STALL : RUN;
        end else begin
            w_nextState = RUN;
        end
    end

    always_comb begin
        STALL_ID_OUT   = 1'b0;
        BUBBLE_EXE_OUT = 1'b0;
        FREEZE_OUT     = 1'b0;
        if (!RESET) begin
            STALL_ID_OUT   = w_bubble;
            BUBBLE_EXE_OUT = w_bubble;
            FREEZE_OUT     = w_freeze;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_exDst <= '0;
            r_exRw  <= 1'b0;
            r_exMr  <= 1'b0;
            r_mmDst <= '0;
            r_mmRw  <= 1'b0;
            r_ctlA  <= CTL_RF;
            r_ctlB  <= CTL_RF;
        end else if (w_advance) begin
            r_mmDst <= r_exDst;
            r_mmRw  <= r_exRw;
            if (w_bubble || !ID_Valid_IN) begin
                r_exDst <= '0;
                r_exRw  <= 1'b0;
                r_exMr  <= 1'b0;
            end else begin
                r_exDst <= ID_WriteRegister_IN;
                r_exRw  <= ID_RegWrite_IN;
                r_exMr  <= ID_MemRead_IN;
            end
            r_ctlA <= w_bubble ? CTL_RF : w_nextA;
            r_ctlB <= w_bubble ? CTL_RF : w_nextB;
        end
    end

    assign Fwd2ALU_opA_ctl = r_ctlA;
    assign Fwd2ALU_opB_ctl = r_ctlB;

`ifdef FWD_STATS_EN
    logic [CNT_W-1:0] r_fwdCount;
    logic [CNT_W-1:0] r_stallCount;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_fwdCount   <= '0;
            r_stallCount <= '0;
        end else begin
            if (w_advance && !w_bubble && ((w_nextA != CTL_RF) || (w_nextB != CTL_RF))) begin
                r_fwdCount <= r_fwdCount + CNT_W'(1);
            end
            if (w_bubble || w_freeze) begin
                r_stallCount <= r_stallCount + CNT_W'(1);
            end
        end
    end

    assign Fwd_Count_OUT   = r_fwdCount;
    assign Stall_Count_OUT = r_stallCount;
`else
    assign Fwd_Count_OUT   = '0;
    assign Stall_Count_OUT = '0;
`endif

endmodule

// File: tb/tb_forward_hazard_ctl.sv
// Directed bench for forward_hazard_ctl: a per-cycle vector table plus
// hand-written freeze-during-load-stall and reset-in-stall sequences.
module tb_forward_hazard_ctl;

    typedef struct {
        string      name;
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       useRs;
        logic       useRt;
        logic [4:0] wr;
        logic       rw;
        logic       mr;
        logic       ready;
        logic [1:0] expA;
        logic [1:0] expB;
        logic       expStall;
        logic       expBubble;
        logic       expFreeze;
    } vec_t;

    logic        CLK;
    logic        RESET;
    logic        ID_Valid_IN;
    logic [4:0]  ID_rs_IN;
    logic [4:0]  ID_rt_IN;
    logic        ID_UsesRs_IN;
    logic        ID_UsesRt_IN;
    logic [4:0]  ID_WriteRegister_IN;
    logic        ID_RegWrite_IN;
    logic        ID_MemRead_IN;
    logic        MEM_Ready_IN;
    logic [1:0]  Fwd2ALU_opA_ctl;
    logic [1:0]  Fwd2ALU_opB_ctl;
    logic        STALL_ID_OUT;
    logic        BUBBLE_EXE_OUT;
    logic        FREEZE_OUT;
    logic [31:0] Fwd_Count_OUT;
    logic [31:0] Stall_Count_OUT;

    int assertCount = 0;
    int failCount   = 0;

    vec_t vecs[21];

    forward_hazard_ctl #(.REG_W(5), .CNT_W(32)) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .ID_Valid_IN         (ID_Valid_IN),
        .ID_rs_IN            (ID_rs_IN),
        .ID_rt_IN            (ID_rt_IN),
        .ID_UsesRs_IN        (ID_UsesRs_IN),
        .ID_UsesRt_IN        (ID_UsesRt_IN),
        .ID_WriteRegister_IN (ID_WriteRegister_IN),
        .ID_RegWrite_IN      (ID_RegWrite_IN),
        .ID_MemRead_IN       (ID_MemRead_IN),
        .MEM_Ready_IN        (MEM_Ready_IN),
        .Fwd2ALU_opA_ctl     (Fwd2ALU_opA_ctl),
        .Fwd2ALU_opB_ctl     (Fwd2ALU_opB_ctl),
        .STALL_ID_OUT        (STALL_ID_OUT),
        .BUBBLE_EXE_OUT      (BUBBLE_EXE_OUT),
        .FREEZE_OUT          (FREEZE_OUT),
        .Fwd_Count_OUT       (Fwd_Count_OUT),
        .Stall_Count_OUT     (Stall_Count_OUT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic vec_t mkVec(string nm, logic v, int rs, int rt, logic ur, logic ut,
                                   int wr, logic rw, logic mr, logic rdy,
                                   logic [1:0] ea, logic [1:0] eb, logic es, logic ebb, logic ef);
        vec_t x;
        x.name      = nm;
        x.valid     = v;
        x.rs        = 5'(rs);
        x.rt        = 5'(rt);
        x.useRs     = ur;
        x.useRt     = ut;
        x.wr        = 5'(wr);
        x.rw        = rw;
        x.mr        = mr;
        x.ready     = rdy;
        x.expA      = ea;
        x.expB      = eb;
        x.expStall  = es;
        x.expBubble = ebb;
        x.expFreeze = ef;
        return x;
    endfunction

    task automatic applyStimulus(input vec_t x);
        ID_Valid_IN         = x.valid;
        ID_rs_IN            = x.rs;
        ID_rt_IN            = x.rt;
        ID_UsesRs_IN        = x.useRs;
        ID_UsesRt_IN        = x.useRt;
        ID_WriteRegister_IN = x.wr;
        ID_RegWrite_IN      = x.rw;
        ID_MemRead_IN       = x.mr;
        MEM_Ready_IN        = x.ready;
    endtask

    task automatic checkOutput(input string nm, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, actual, expected);
        end
    endtask

    task automatic checkAll(input string nm, input logic [1:0] ea, input logic [1:0] eb,
                            input logic es, input logic ebb, input logic ef);
        checkOutput({nm, " opA"},    32'(Fwd2ALU_opA_ctl), 32'(ea));
        checkOutput({nm, " opB"},    32'(Fwd2ALU_opB_ctl), 32'(eb));
        checkOutput({nm, " stall"},  32'(STALL_ID_OUT),    32'(es));
        checkOutput({nm, " bubble"}, 32'(BUBBLE_EXE_OUT),  32'(ebb));
        checkOutput({nm, " freeze"}, 32'(FREEZE_OUT),      32'(ef));
    endtask

    task automatic stepEdge();
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        RESET = 1'b1;
        applyStimulus(mkVec("idle", 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0));
        stepEdge();
        stepEdge();
        RESET = 1'b0;
    endtask

    initial begin
        // Ctl shown on each row is the value registered by the previous row's edge.
        vecs[0]  = mkVec("add3",       1, 1, 2, 1, 1, 3, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0);
        vecs[1]  = mkVec("sub4_use3",  1, 3, 5, 1, 1, 4, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0);
        vecs[2]  = mkVec("sub_in_exe", 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 0, 0);
        vecs[3]  = mkVec("add3_b",     1, 1, 2, 1, 1, 3, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0);
        vecs[4]  = mkVec("nop",        0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0);
        vecs[5]  = mkVec("or6_rt3",    1, 5, 3, 1, 1, 6, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0);
        vecs[6]  = mkVec("add3_c",     1, 1, 2, 1, 1, 3, 1, 0, 1, 2'b00, 2'b10, 0, 0, 0);
        vecs[7]  = mkVec("add3_d",     1, 1, 2, 1, 1, 3, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0);
        vecs[8]  = mkVec("sub8_33",    1, 3, 3, 1, 1, 8, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0);
        vecs[9]  = mkVec("lw2",        1, 1, 0, 1, 0, 2, 1, 1, 1, 2'b01, 2'b01, 0, 0, 0);
        vecs[10] = mkVec("add4_22",    1, 2, 2, 1, 1, 4, 1, 0, 1, 2'b00, 2'b00, 1, 1, 0);
        vecs[11] = mkVec("add4_held",  1, 2, 2, 1, 1, 4, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0);
        vecs[12] = mkVec("add_in_exe", 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0);
        vecs[13] = mkVec("addi0",      1, 1, 0, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0);
        vecs[14] = mkVec("add7_00",    1, 0, 0, 1, 1, 7, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0);
        vecs[15] = mkVec("nop_b",      0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0);
        vecs[16] = mkVec("use7_rsonly",1, 7, 7, 1, 0, 9, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0);
        vecs[17] = mkVec("nop_c",      0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0);
        vecs[18] = mkVec("use9_frz",   1, 9, 1, 1, 1,10, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        vecs[19] = mkVec("use9_go",    1, 9, 1, 1, 1,10, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0);
        vecs[20] = mkVec("nop_d",      0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0);

        RESET = 1'b1;
        applyStimulus(mkVec("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        stepEdge();
        stepEdge();
        @(negedge CLK);
        checkAll("reset_hold_not_ready", 2'b00, 2'b00, 0, 0, 0);
        checkOutput("reset fwd_count",   Fwd_Count_OUT,   32'd0);
        checkOutput("reset stall_count", Stall_Count_OUT, 32'd0);
        MEM_Ready_IN = 1'b1;
        stepEdge();
        RESET = 1'b0;

        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i]);
            @(negedge CLK);
            checkAll(vecs[i].name, vecs[i].expA, vecs[i].expB,
                     vecs[i].expStall, vecs[i].expBubble, vecs[i].expFreeze);
            stepEdge();
        end

        // MEM not ready for three cycles while a load-use hazard waits in ID.
        doReset();
        applyStimulus(mkVec("lw2", 1, 1, 0, 1, 0, 2, 1, 1, 1, 2'b00, 2'b00, 0, 0, 0));
        stepEdge();
        applyStimulus(mkVec("add4_22", 1, 2, 2, 1, 1, 4, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            checkAll($sformatf("frz_lw_%0d", k), 2'b00, 2'b00, 0, 0, 1);
            stepEdge();
        end
        MEM_Ready_IN = 1'b1;
        @(negedge CLK);
        checkAll("frz_release_bubble", 2'b00, 2'b00, 1, 1, 0);
        stepEdge();
        @(negedge CLK);
        checkAll("frz_loadstall", 2'b00, 2'b00, 0, 0, 0);
        stepEdge();
        applyStimulus(mkVec("nop", 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0));
        @(negedge CLK);
        checkAll("frz_add_in_exe", 2'b10, 2'b10, 0, 0, 0);
        stepEdge();

        // Reset while in LOAD_STALL must leave no residual stall, freeze or tags.
        doReset();
        applyStimulus(mkVec("lw2", 1, 1, 0, 1, 0, 2, 1, 1, 1, 2'b00, 2'b00, 0, 0, 0));
        stepEdge();
        applyStimulus(mkVec("add4_22", 1, 2, 2, 1, 1, 4, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0));
        @(negedge CLK);
        checkAll("rst_seq_bubble", 2'b00, 2'b00, 1, 1, 0);
        stepEdge();
        RESET = 1'b1;
        MEM_Ready_IN = 1'b0;
        @(negedge CLK);
        checkAll("rst_in_stall", 2'b00, 2'b00, 0, 0, 0);
        stepEdge();
        RESET = 1'b0;
        MEM_Ready_IN = 1'b1;
        @(negedge CLK);
        checkAll("rst_after", 2'b00, 2'b00, 0, 0, 0);
        checkOutput("rst_after fwd_count",   Fwd_Count_OUT,   32'd0);
        checkOutput("rst_after stall_count", Stall_Count_OUT, 32'd0);
        stepEdge();
        applyStimulus(mkVec("nop", 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0));
        @(negedge CLK);
        checkAll("rst_tags_cleared", 2'b00, 2'b00, 0, 0, 0);
        stepEdge();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
